dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 2048, meaning data storage size in bytes (multiple of 4).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1, meaning the initiator presents an access.
REQ-005 SHALL have port req_ready, output, 1, meaning the block can accept an access this cycle.
REQ-006 SHALL have port req_write, input, 1, meaning 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3, meaning RV32I load/store width and sign code.
REQ-008 SHALL have port req_addr, input, 32, meaning byte address.
REQ-009 SHALL have port req_wdata, input, 32, meaning store data, right-aligned.
REQ-010 SHALL have port rsp_valid, output, 1, meaning a one-cycle response pulse.
REQ-011 SHALL have port rsp_rdata, output, 32, meaning the extended load result; 0 for stores and errors.
REQ-012 SHALL have port rsp_err, output, 1, meaning the access was rejected; valid only with rsp_valid.

Function
REQ-013 SHALL accept a request only on a cycle where req_valid and req_ready are both 1, capturing all request fields that cycle.
REQ-014 SHALL use FSM states IDLE, BEAT1, BEAT2, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL make these transitions: IDLE to BEAT1 on accept; BEAT1 to BEAT2 if the access crosses a word boundary, else to RESP; BEAT2 to RESP; RESP to IDLE.
REQ-016 SHALL assert rsp_valid for exactly one cycle in RESP; there is no response backpressure.
REQ-017 SHALL decode loads as: funct3 0 = LB (sign-extend), 1 = LH (sign-extend), 2 = LW, 4 = LBU (zero-extend), 5 = LHU (zero-extend).
REQ-018 SHALL decode stores as: funct3 0 = SB, 1 = SH, 2 = SW, writing only the addressed byte lanes.
REQ-019 SHALL treat other funct3 codes (loads 3, 6, 7; stores 3 to 7) as errors: rsp_err = 1, no write, rsp_rdata = 0.
REQ-020 SHALL treat any access whose last byte is at or beyond MEM_SIZE as an error: rsp_err = 1, no write.
REQ-021 SHALL NOT perform any partial write for an errored access.
REQ-022 SHALL give a latency from accept to rsp_valid of 2 cycles for aligned or in-word accesses and 3 cycles for split accesses.
REQ-023 SHALL, for a split access, store the lower-address bytes in BEAT1 and the remaining bytes to the next word in BEAT2; loads SHALL merge both beats before extension.
REQ-024 SHALL make a load that follows a store to the same bytes return the newly stored data.
REQ-025 SHALL ignore req_valid while req_ready = 0; inputs held over from a previous request SHALL NOT be re-accepted until IDLE.

Reset
REQ-026 SHALL, on rst, set the state to IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, and rsp_err = 0 on the next edge.
REQ-027 SHALL leave storage contents unchanged on rst.
REQ-028 SHALL, when rst is asserted in BEAT2 of a split store, suppress the BEAT2 write; the BEAT1 bytes remain written and no response is issued.

Configuration
REQ-029 SHALL, when DMEM_MISALIGN_EN is defined, support word-crossing accesses as REQ-023.
REQ-030 SHALL, when DMEM_MISALIGN_EN is undefined, reject halfword accesses not aligned to 2 bytes and word accesses not aligned to 4 bytes with rsp_err = 1 at 2-cycle latency and no write; BEAT2 is then unreachable.

Structure
REQ-031 SHALL take the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state enum from shared package dmem_pkg.
REQ-032 SHALL instantiate one sub-module, dmem_ram: a word array of MEM_SIZE/4 entries with a 4-bit byte-enable write and a synchronous read.

Verification
REQ-033 SHALL cover an aligned word store then load: SW addr 0x100, data 0xDEADBEEF, then LW 0x100 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid 2 cycles after each accept.
REQ-034 SHALL cover sign handling: after SW 0x104 = 0x000080F0, LB 0x104 -> 0xFFFFFFF0; LBU 0x104 -> 0x000000F0; LH 0x104 -> 0xFFFF80F0; LHU 0x104 -> 0x000080F0.
REQ-035 SHALL cover a split access with the macro defined: SW 0x202 = 0x11223344, then LW 0x200 -> 0x33440000 and LW 0x204 -> 0x00001122; the split store's response arrives at 3-cycle latency.
REQ-036 SHALL cover the misalignment error with the macro undefined: LW 0x202 -> rsp_err 1, rsp_rdata 0; a later LW 0x200 shows the memory unchanged.
REQ-037 SHALL cover the range and funct3 errors with MEM_SIZE 2048: SW 0x7FE -> rsp_err 1; SW 0x7FC -> rsp_err 0; a load with funct3 3 -> rsp_err 1, no write.
REQ-038 SHALL cover reset during a split store: assert rst in BEAT2 of SW 0x3FE -> no rsp_valid, req_ready 1 the next cycle, bytes at 0x3FE–0x3FF written, bytes at 0x400–0x401 unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states
// and the load extension helper.
package dmem_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2,
    RESP  = 2'd3
  } dmem_state_t;

  // Number of bytes touched by an access, from the low two funct3 bits.
  function automatic logic [2:0] access_bytes(input logic [1:0] size_code);
    case (size_code)
      2'd0:    access_bytes = 3'd1;
      2'd1:    access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [31:0] raw);
    case (funct3)
      LB:      load_extend = {{24{raw[7]}}, raw[7:0]};
      LH:      load_extend = {{16{raw[15]}}, raw[15:0]};
      LBU:     load_extend = {24'h0, raw[7:0]};
      LHU:     load_extend = {16'h0, raw[15:0]};
      default: load_extend = raw;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data storage with per-byte write enables and a registered read.
module dmem_ram #(
  parameter int WORDS = 512,
  parameter int IDX_W = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// RV32I load/store responder over a byte-enabled word RAM. Word-crossing
// accesses are supported only when DMEM_MISALIGN_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int MEM_SIZE = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int WORDS = MEM_SIZE / 4;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  dmem_state_t state;

  logic             cap_write;
  logic [2:0]       cap_funct3;
  logic [1:0]       cap_off;
  logic [IDX_W-1:0] cap_idx;
  logic             cap_err;
  logic             cap_split;
  logic [7:0]       cap_be;
  logic [63:0]      cap_wdata;
  logic [31:0]      word0_q;

  logic [2:0]  req_bytes;
  logic [32:0] last_byte;
  logic        f3_bad;
  logic        range_bad;
  logic        align_bad;
  logic        crosses;
  logic        req_err;
  logic        req_split;
  logic [3:0]  be4;
  logic [7:0]  req_be;
  logic [63:0] req_wdata64;

  // Decode the presented request so everything needed later is captured on accept.
  always_comb begin
    req_bytes   = access_bytes(req_funct3[1:0]);
    f3_bad      = req_write ? (req_funct3 > SW)
                            : !(req_funct3 == LB || req_funct3 == LH || req_funct3 == LW ||
                                req_funct3 == LBU || req_funct3 == LHU);
    last_byte   = {1'b0, req_addr} + {30'd0, req_bytes} - 33'd1;
    range_bad   = last_byte >= 33'(MEM_SIZE);
    crosses     = ({1'b0, req_addr[1:0]} + req_bytes) > 3'd4;
`ifdef DMEM_MISALIGN_EN
    align_bad   = 1'b0;
`else
    align_bad   = (req_bytes == 3'd2 && req_addr[0]) ||
                  (req_bytes == 3'd4 && req_addr[1:0] != 2'b00);
`endif
    req_err     = f3_bad || range_bad || align_bad;
    req_split   = crosses && !req_err;
    be4         = (req_bytes == 3'd1) ? 4'b0001 : (req_bytes == 3'd2) ? 4'b0011 : 4'b1111;
    req_be      = {4'b0000, be4} << req_addr[1:0];
    req_wdata64 = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
  end

  logic             ram_we;
  logic [3:0]       ram_be;
  logic [IDX_W-1:0] ram_waddr;
  logic [31:0]      ram_wdata;
  logic [IDX_W-1:0] ram_raddr;
  logic [31:0]      ram_rdata;
  logic [63:0]      merged;
  logic [31:0]      load_result;

  // Reads are issued one cycle ahead of the beat that consumes them; writes
  // happen during the beats and are dropped whenever rst is high.
  always_comb begin
    ram_we      = !rst && cap_write && !cap_err && (state == BEAT1 || state == BEAT2);
    ram_be      = (state == BEAT2) ? cap_be[7:4] : cap_be[3:0];
    ram_waddr   = (state == BEAT2) ? cap_idx + IDX_W'(1) : cap_idx;
    ram_wdata   = (state == BEAT2) ? cap_wdata[63:32] : cap_wdata[31:0];
    ram_raddr   = (state == IDLE) ? req_addr[IDX_W+1:2] : cap_idx + IDX_W'(1);
    merged      = (state == BEAT2) ? {ram_rdata, word0_q} : {32'h0, ram_rdata};
    load_result = load_extend(cap_funct3, merged[{cap_off, 3'b000} +: 32]);
  end

  dmem_ram #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_write  <= req_write;
            cap_funct3 <= req_funct3;
            cap_off    <= req_addr[1:0];
            cap_idx    <= req_addr[IDX_W+1:2];
            cap_err    <= req_err;
            cap_split  <= req_split;
            cap_be     <= req_be;
            cap_wdata  <= req_wdata64;
            req_ready  <= 1'b0;
            state      <= BEAT1;
          end
        end
        BEAT1: begin
          word0_q <= ram_rdata;
          if (cap_split) begin
            state <= BEAT2;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= cap_err;
            rsp_rdata <= (cap_err || cap_write) ? 32'h0 : load_result;
          end
        end
        BEAT2: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= cap_write ? 32'h0 : load_result;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; the word-crossing section
// is selected by DMEM_MISALIGN_EN to match the build of the design.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  int          obs_lat;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic        obs_busy_ready;
  logic        obs_valid_after;

  dmem_responder #(.MEM_SIZE(2048)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request, then record latency, response fields and the cycle after.
  task automatic applyStimulus(input logic w, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] d);
    int waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clk);
    #1;
    req_valid       = 1'b0;
    obs_lat         = 99;
    obs_rdata       = 'x;
    obs_err         = 1'bx;
    obs_busy_ready  = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) obs_busy_ready = req_ready;
      if (rsp_valid) begin
        obs_lat   = c;
        obs_rdata = rsp_rdata;
        obs_err   = rsp_err;
        break;
      end
    end
    @(negedge clk);
    obs_valid_after = rsp_valid;
  endtask

  task automatic expectResponse(input string tag, input int lat, input logic [31:0] rdata,
                                input logic err);
    checkOutput({tag, " latency"}, 32'(obs_lat), 32'(lat));
    checkOutput({tag, " rdata"}, obs_rdata, rdata);
    checkOutput({tag, " err"}, {31'h0, obs_err}, {31'h0, err});
    checkOutput({tag, " pulse"}, {31'h0, obs_valid_after}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ready", {31'h0, req_ready}, 32'h1);
    checkOutput("reset valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("reset rdata", rsp_rdata, 32'h0);
    checkOutput("reset err", {31'h0, rsp_err}, 32'h0);
    rst = 1'b0;

    applyStimulus(1'b1, SW, 32'h100, 32'hDEADBEEF);
    expectResponse("sw 0x100", 2, 32'h0, 1'b0);
    checkOutput("busy ready", {31'h0, obs_busy_ready}, 32'h0);
    applyStimulus(1'b0, LW, 32'h100, 32'h0);
    expectResponse("lw 0x100", 2, 32'hDEADBEEF, 1'b0);

    applyStimulus(1'b1, SW, 32'h104, 32'h000080F0);
    expectResponse("sw 0x104", 2, 32'h0, 1'b0);
    applyStimulus(1'b0, LB, 32'h104, 32'h0);
    expectResponse("lb 0x104", 2, 32'hFFFFFFF0, 1'b0);
    applyStimulus(1'b0, LBU, 32'h104, 32'h0);
    expectResponse("lbu 0x104", 2, 32'h000000F0, 1'b0);
    applyStimulus(1'b0, LH, 32'h104, 32'h0);
    expectResponse("lh 0x104", 2, 32'hFFFF80F0, 1'b0);
    applyStimulus(1'b0, LHU, 32'h104, 32'h0);
    expectResponse("lhu 0x104", 2, 32'h000080F0, 1'b0);

    applyStimulus(1'b1, SB, 32'h105, 32'hFFFFFFAB);
    expectResponse("sb 0x105", 2, 32'h0, 1'b0);
    applyStimulus(1'b0, LH, 32'h104, 32'h0);
    expectResponse("lh after sb", 2, 32'hFFFFABF0, 1'b0);
    applyStimulus(1'b1, SW, 32'h108, 32'h0);
    expectResponse("sw 0x108", 2, 32'h0, 1'b0);
    applyStimulus(1'b1, SH, 32'h10A, 32'hFFFF1234);
    expectResponse("sh 0x10a", 2, 32'h0, 1'b0);
    applyStimulus(1'b0, LW, 32'h108, 32'h0);
    expectResponse("lw 0x108", 2, 32'h12340000, 1'b0);

    // Range boundary at the top of a 2048-byte store.
    applyStimulus(1'b1, SW, 32'h7FE, 32'h99999999);
    expectResponse("sw 0x7fe", 2, 32'h0, 1'b1);
    applyStimulus(1'b1, SW, 32'h7FC, 32'hCAFEF00D);
    expectResponse("sw 0x7fc", 2, 32'h0, 1'b0);
    applyStimulus(1'b0, LW, 32'h7FC, 32'h0);
    expectResponse("lw 0x7fc", 2, 32'hCAFEF00D, 1'b0);
    applyStimulus(1'b1, SH, 32'h7FE, 32'h00005555);
    expectResponse("sh 0x7fe", 2, 32'h0, 1'b0);
    applyStimulus(1'b1, SB, 32'h800, 32'h00000077);
    expectResponse("sb 0x800", 2, 32'h0, 1'b1);
    applyStimulus(1'b0, LW, 32'h7FC, 32'h0);
    expectResponse("lw 0x7fc again", 2, 32'h5555F00D, 1'b0);

    applyStimulus(1'b0, 3'd3, 32'h100, 32'h0);
    expectResponse("load f3=3", 2, 32'h0, 1'b1);
    applyStimulus(1'b1, 3'd3, 32'h100, 32'h0);
    expectResponse("store f3=3", 2, 32'h0, 1'b1);
    applyStimulus(1'b1, 3'd5, 32'h100, 32'h0);
    expectResponse("store f3=5", 2, 32'h0, 1'b1);
    applyStimulus(1'b0, LW, 32'h100, 32'h0);
    expectResponse("lw 0x100 kept", 2, 32'hDEADBEEF, 1'b0);

`ifdef DMEM_MISALIGN_EN
    applyStimulus(1'b1, SW, 32'h200, 32'h0);
    expectResponse("sw 0x200", 2, 32'h0, 1'b0);
    applyStimulus(1'b1, SW, 32'h204, 32'h0);
    expectResponse("sw 0x204", 2, 32'h0, 1'b0);
    applyStimulus(1'b1, SW, 32'h202, 32'h11223344);
    expectResponse("split sw 0x202", 3, 32'h0, 1'b0);
    applyStimulus(1'b0, LW, 32'h200, 32'h0);
    expectResponse("lw 0x200", 2, 32'h33440000, 1'b0);
    applyStimulus(1'b0, LW, 32'h204, 32'h0);
    expectResponse("lw 0x204", 2, 32'h00001122, 1'b0);
    applyStimulus(1'b0, LW, 32'h202, 32'h0);
    expectResponse("split lw 0x202", 3, 32'h11223344, 1'b0);
    applyStimulus(1'b0, LH, 32'h203, 32'h0);
    expectResponse("split lh 0x203", 3, 32'h00002233, 1'b0);
    applyStimulus(1'b0, LW, 32'h7FE, 32'h0);
    expectResponse("split lw 0x7fe", 2, 32'h0, 1'b1);

    // Reset lands in BEAT2 of a split store: only the lower word is written.
    applyStimulus(1'b1, SW, 32'h3FC, 32'hAAAAAAAA);
    expectResponse("sw 0x3fc", 2, 32'h0, 1'b0);
    applyStimulus(1'b1, SW, 32'h400, 32'h55555555);
    expectResponse("sw 0x400", 2, 32'h0, 1'b0);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = SW;
    req_addr   = 32'h3FE;
    req_wdata  = 32'h11223344;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst beat2 valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("rst beat2 ready", {31'h0, req_ready}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst beat2 no rsp", {31'h0, rsp_valid}, 32'h0);
    applyStimulus(1'b0, LW, 32'h3FC, 32'h0);
    expectResponse("lw 0x3fc after rst", 2, 32'h3344AAAA, 1'b0);
    applyStimulus(1'b0, LW, 32'h400, 32'h0);
    expectResponse("lw 0x400 after rst", 2, 32'h55555555, 1'b0);
`else
    applyStimulus(1'b1, SW, 32'h200, 32'h01020304);
    expectResponse("sw 0x200", 2, 32'h0, 1'b0);
    applyStimulus(1'b0, LW, 32'h202, 32'h0);
    expectResponse("misaligned lw", 2, 32'h0, 1'b1);
    applyStimulus(1'b1, SW, 32'h202, 32'h11223344);
    expectResponse("misaligned sw", 2, 32'h0, 1'b1);
    applyStimulus(1'b1, SH, 32'h201, 32'h0000BBBB);
    expectResponse("misaligned sh", 2, 32'h0, 1'b1);
    applyStimulus(1'b0, LW, 32'h200, 32'h0);
    expectResponse("lw 0x200 kept", 2, 32'h01020304, 1'b0);
    applyStimulus(1'b0, LHU, 32'h202, 32'h0);
    expectResponse("aligned lhu 0x202", 2, 32'h00000102, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
